// File: rtl/reduce_pkg.sv
// Shared definitions for the pipelined N-way reduction block.
// Holds the operator encodings, the identity element used to pad partial
// tree nodes, and the constant functions that size the reduction tree.
package reduce_pkg;

    localparam logic [1:0] MODE_AND  = 2'b00;
    localparam logic [1:0] MODE_OR   = 2'b01;
    localparam logic [1:0] MODE_XOR  = 2'b10;
    localparam logic [1:0] MODE_NAND = 2'b11;

    // Number of tree levels: smallest L with fanin**L >= width.
    function automatic int clog_base(input int width, input int fanin);
        int levels;
        int span;
        levels = 0;
        span   = 1;
        while (span < width) begin
            span   = span * fanin;
            levels = levels + 1;
        end
        return levels;
    endfunction

    // Neutral element of the node operator: AND-type modes pad with 1,
    // OR/XOR pad with 0, so padded leaves never change the result.
    function automatic logic identity_bit(input logic [1:0] mode);
        return (mode == MODE_OR || mode == MODE_XOR) ? 1'b0 : 1'b1;
    endfunction

    // Bit count entering tree level 'level' (level 0 is the raw input).
    function automatic int level_width(input int width, input int fanin, input int level);
        int w;
        w = width;
        for (int i = 0; i < level; i++) begin
            w = (w + fanin - 1) / fanin;
        end
        return w;
    endfunction

    // Bit offset of level 'level' inside a bus that concatenates all levels.
    function automatic int level_offset(input int width, input int fanin, input int level);
        int off;
        off = 0;
        for (int i = 0; i < level; i++) begin
            off = off + level_width(width, fanin, i);
        end
        return off;
    endfunction

endpackage

// File: rtl/reduce_stage.sv
// One registered level of the reduction tree.
// Combines groups of FANIN bits from the previous level into OUT_W bits and
// registers them together with the mode and a valid bit.
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   prev_data/mode/valid  item offered by the previous level (or block input)
//   prev_ready            this level can load this cycle
//   data/mode/valid       registered item held by this level
//   next_ready            the following level (or consumer) can take our item
module reduce_stage
    import reduce_pkg::*;
#(
    parameter int IN_W  = 16,
    parameter int FANIN = 4,
    parameter int OUT_W = (IN_W + FANIN - 1) / FANIN,
    parameter bit LAST  = 1'b0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [IN_W-1:0]  prev_data,
    input  logic [1:0]       prev_mode,
    input  logic             prev_valid,
    output logic             prev_ready,
    output logic [OUT_W-1:0] data,
    output logic [1:0]       mode,
    output logic             valid,
    input  logic             next_ready
);

    logic [OUT_W*FANIN-1:0] padded;
    logic [OUT_W-1:0]       node;

    // An empty level always accepts; a full one only if it can hand off.
    assign prev_ready = !valid || next_ready;

    // Pad the incomplete last group with the identity element, reduce each
    // group, and apply the NAND inversion only once, at the tree root.
    always_comb begin
        padded            = {(OUT_W*FANIN){identity_bit(prev_mode)}};
        padded[IN_W-1:0]  = prev_data;
        node              = '0;
        for (int n = 0; n < OUT_W; n++) begin
            case (prev_mode)
                MODE_OR:  node[n] = |padded[n*FANIN +: FANIN];
                MODE_XOR: node[n] = ^padded[n*FANIN +: FANIN];
                default:  node[n] = &padded[n*FANIN +: FANIN];
            endcase
        end
        if (LAST && prev_mode == MODE_NAND) begin
            node = ~node;
        end
    end

    // Data, mode and valid move together whenever this level can load.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid <= 1'b0;
            data  <= '0;
            mode  <= '0;
        end else if (prev_ready) begin
            valid <= prev_valid;
            data  <= node;
            mode  <= prev_mode;
        end
    end

endmodule

// File: rtl/reduce_n_way_pipe.sv
// Pipelined, elastic WIDTH-bit to 1-bit reduction (AND/OR/XOR/NAND).
// A FANIN-ary tree with one register per level; latency equals the number
// of levels, throughput is one item per cycle, valid/ready on both sides.
// Ports:
//   clk, rst_n                   clock, asynchronous active-low reset
//   in_data, in_mode, in_valid   operand vector, operator, input valid
//   in_ready                     block accepts the input this cycle
//   out_data, out_mode           result and the mode it was computed with
//   out_valid, out_ready         output handshake
module reduce_n_way_pipe
    import reduce_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int FANIN = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] in_data,
    input  logic [1:0]       in_mode,
    input  logic             in_valid,
    output logic             in_ready,
    output logic             out_data,
    output logic [1:0]       out_mode,
    output logic             out_valid,
    input  logic             out_ready
);

    localparam int LEVELS  = clog_base(WIDTH, FANIN);
    localparam int TOTAL_W = level_offset(WIDTH, FANIN, LEVELS + 1);

    // All levels' data concatenated; level 0 is the input, the top bit is
    // the final result.
    logic [TOTAL_W-1:0]      data_bus;
    logic [2*(LEVELS+1)-1:0] mode_bus;
    logic [LEVELS:0]         valid_bus;

    assign data_bus[WIDTH-1:0] = in_data;
    assign mode_bus[1:0]       = in_mode;
    assign valid_bus[0]        = in_valid;

    // Ready is kept as one signal per level so the combinational ready
    // chain runs through separate nets rather than one shared vector.
    for (genvar k = 0; k < LEVELS; k++) begin : g_stage
        localparam int IW     = level_width(WIDTH, FANIN, k);
        localparam int OW     = level_width(WIDTH, FANIN, k + 1);
        localparam int OFF_IN = level_offset(WIDTH, FANIN, k);
        localparam int OFF_OUT = OFF_IN + IW;

        logic ready;
        logic next_ready;

        if (k == LEVELS - 1) begin : g_tail
            assign next_ready = out_ready;
        end else begin : g_link
            assign next_ready = g_stage[k+1].ready;
        end

        reduce_stage #(
            .IN_W  (IW),
            .FANIN (FANIN),
            .LAST  (k == LEVELS - 1)
        ) u_stage (
            .clk        (clk),
            .rst_n      (rst_n),
            .prev_data  (data_bus[OFF_IN +: IW]),
            .prev_mode  (mode_bus[2*k +: 2]),
            .prev_valid (valid_bus[k]),
            .prev_ready (ready),
            .data       (data_bus[OFF_OUT +: OW]),
            .mode       (mode_bus[2*(k+1) +: 2]),
            .valid      (valid_bus[k+1]),
            .next_ready (next_ready)
        );
    end

    assign in_ready  = g_stage[0].ready;
    assign out_data  = data_bus[TOTAL_W-1];
    assign out_mode  = mode_bus[2*LEVELS +: 2];
    assign out_valid = valid_bus[LEVELS];

endmodule

// File: tb/tb_reduce_n_way_pipe.sv
// Self-checking bench for reduce_n_way_pipe.
// Three instances: 16/4 (scoreboarded main DUT), 3/2 and 5/4 (padded tree).
module tb_reduce_n_way_pipe;

    typedef struct {
        logic [2:0] d3;
        logic       e3;
        logic [4:0] d5;
        logic [1:0] m5;
        logic       e5;
    } small_vec_t;

    typedef struct {
        logic [15:0] data;
        logic [1:0]  mode;
        logic        exp;
    } main_vec_t;

    typedef struct {
        logic       data;
        logic [1:0] mode;
    } sb_t;

    logic clk;
    logic rst_n;

    logic [15:0] m_data;
    logic [1:0]  m_mode;
    logic        m_valid, m_in_ready, m_out_data, m_out_valid, m_ready;
    logic [1:0]  m_out_mode;

    logic [2:0]  s3_data;
    logic [1:0]  s3_mode;
    logic        s3_valid, s3_in_ready, s3_out_data, s3_out_valid;
    logic [1:0]  s3_out_mode;

    logic [4:0]  s5_data;
    logic [1:0]  s5_mode;
    logic        s5_valid, s5_in_ready, s5_out_data, s5_out_valid;
    logic [1:0]  s5_out_mode;

    logic        s_ready;

    int checks = 0;
    int errors = 0;
    int pushed = 0;
    int received = 0;
    int base_push, base_recv, wait_cnt;
    int ready_mode;
    sb_t sb_q[$];
    sb_t mon_item;
    small_vec_t sv[8];
    main_vec_t  mv[4];
    main_vec_t  bp[4];

    reduce_n_way_pipe #(.WIDTH(16), .FANIN(4)) u_main (
        .clk(clk), .rst_n(rst_n), .in_data(m_data), .in_mode(m_mode),
        .in_valid(m_valid), .in_ready(m_in_ready), .out_data(m_out_data),
        .out_mode(m_out_mode), .out_valid(m_out_valid), .out_ready(m_ready));

    reduce_n_way_pipe #(.WIDTH(3), .FANIN(2)) u_w3 (
        .clk(clk), .rst_n(rst_n), .in_data(s3_data), .in_mode(s3_mode),
        .in_valid(s3_valid), .in_ready(s3_in_ready), .out_data(s3_out_data),
        .out_mode(s3_out_mode), .out_valid(s3_out_valid), .out_ready(s_ready));

    reduce_n_way_pipe #(.WIDTH(5), .FANIN(4)) u_w5 (
        .clk(clk), .rst_n(rst_n), .in_data(s5_data), .in_mode(s5_mode),
        .in_valid(s5_valid), .in_ready(s5_in_ready), .out_data(s5_out_data),
        .out_mode(s5_out_mode), .out_valid(s5_out_valid), .out_ready(s_ready));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Independent reference: plain reduction operators over the whole word.
    function automatic logic ref_reduce(input logic [15:0] d, input logic [1:0] m);
        case (m)
            2'b00:   return &d;
            2'b01:   return |d;
            2'b10:   return ^d;
            default: return ~(&d);
        endcase
    endfunction

    task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Offer one item to the main DUT and hold it until accepted (bounded).
    task automatic apply_stimulus(input logic [15:0] d, input logic [1:0] m);
        int waited;
        waited  = 0;
        m_data  = d;
        m_mode  = m;
        m_valid = 1'b1;
        @(negedge clk);
        while (!m_in_ready && waited < 100) begin
            @(negedge clk);
            waited++;
        end
        if (waited >= 100) check_output("accept_in_ready", 32'(m_in_ready), 32'd1);
        @(posedge clk);
        #1;
        m_valid = 1'b0;
    endtask

    // Consumer: drives out_ready mid-cycle (0, 1 or random per ready_mode).
    initial begin
        m_ready = 1'b0;
        forever begin
            @(posedge clk);
            #3;
            case (ready_mode)
                0:       m_ready = 1'b0;
                1:       m_ready = 1'b1;
                default: m_ready = 1'($urandom_range(0, 1));
            endcase
        end
    end

    // Scoreboard monitor: sampled at the falling edge, reflects the
    // transfers that the next rising edge will perform.
    always @(negedge clk) begin
        if (!rst_n) begin
            sb_q.delete();
        end else begin
            if (m_out_valid && m_ready) begin
                if (sb_q.size() == 0) begin
                    check_output("sb_unexpected_valid", 32'(m_out_valid), 32'd0);
                end else begin
                    mon_item = sb_q.pop_front();
                    check_output("sb_data", 32'(m_out_data), 32'(mon_item.data));
                    check_output("sb_mode", 32'(m_out_mode), 32'(mon_item.mode));
                    received++;
                end
            end
            if (m_valid && m_in_ready) begin
                sb_q.push_back('{ref_reduce(m_data, m_mode), m_mode});
                pushed++;
            end
        end
    end

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation did not complete");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        sv[0] = '{3'd0, 1'b0, 5'b10000, 2'b10, 1'b1};
        sv[1] = '{3'd1, 1'b0, 5'b11111, 2'b00, 1'b1};
        sv[2] = '{3'd2, 1'b0, 5'b00000, 2'b01, 1'b0};
        sv[3] = '{3'd3, 1'b0, 5'b10000, 2'b01, 1'b1};
        sv[4] = '{3'd4, 1'b0, 5'b10000, 2'b00, 1'b0};
        sv[5] = '{3'd5, 1'b0, 5'b11111, 2'b11, 1'b0};
        sv[6] = '{3'd6, 1'b0, 5'b01111, 2'b11, 1'b1};
        sv[7] = '{3'd7, 1'b1, 5'b10001, 2'b10, 1'b0};

        mv[0] = '{16'hFFFE, 2'b00, 1'b0};
        mv[1] = '{16'hFFFE, 2'b01, 1'b1};
        mv[2] = '{16'hFFFE, 2'b10, 1'b1};
        mv[3] = '{16'hFFFE, 2'b11, 1'b1};

        bp[0] = '{16'hFFFF, 2'b00, 1'b1};
        bp[1] = '{16'h0000, 2'b01, 1'b0};
        bp[2] = '{16'h0003, 2'b10, 1'b0};
        bp[3] = '{16'hFFFF, 2'b11, 1'b0};

        rst_n = 1'b0;
        ready_mode = 1;
        m_data = '0; m_mode = '0; m_valid = 1'b0;
        s3_data = '0; s3_mode = 2'b00; s3_valid = 1'b0;
        s5_data = '0; s5_mode = 2'b00; s5_valid = 1'b0;
        s_ready = 1'b1;

        // Reset state
        repeat (3) tick();
        check_output("rst_out_valid", 32'(m_out_valid), 32'd0);
        check_output("rst_out_data", 32'(m_out_data), 32'd0);
        check_output("rst_out_mode", 32'(m_out_mode), 32'd0);
        check_output("rst_in_ready", 32'(m_in_ready), 32'd1);
        check_output("rst_w3_out_valid", 32'(s3_out_valid), 32'd0);
        rst_n = 1'b1;
        tick();
        check_output("post_rst_in_ready", 32'(m_in_ready), 32'd1);
        check_output("post_rst_out_valid", 32'(m_out_valid), 32'd0);

        // W3 sweep and W5 padded tree, both with exact 2-cycle latency
        for (int i = 0; i < 10; i++) begin
            if (i < 8) begin
                s3_data = sv[i].d3; s3_valid = 1'b1;
                s5_data = sv[i].d5; s5_mode = sv[i].m5; s5_valid = 1'b1;
            end else begin
                s3_valid = 1'b0; s5_valid = 1'b0;
            end
            tick();
            check_output("w3_in_ready", 32'(s3_in_ready), 32'd1);
            if (i >= 1 && i <= 8) begin
                check_output("w3_out_valid", 32'(s3_out_valid), 32'd1);
                check_output("w3_out_data", 32'(s3_out_data), 32'(sv[i-1].e3));
                check_output("w3_out_mode", 32'(s3_out_mode), 32'd0);
                check_output("w5_out_valid", 32'(s5_out_valid), 32'd1);
                check_output("w5_out_data", 32'(s5_out_data), 32'(sv[i-1].e5));
                check_output("w5_out_mode", 32'(s5_out_mode), 32'(sv[i-1].m5));
            end else begin
                check_output("w3_out_valid_idle", 32'(s3_out_valid), 32'd0);
                check_output("w5_out_valid_idle", 32'(s5_out_valid), 32'd0);
            end
        end

        // Mixed modes back-to-back on the main DUT
        for (int i = 0; i < 6; i++) begin
            if (i < 4) begin
                m_data = mv[i].data; m_mode = mv[i].mode; m_valid = 1'b1;
            end else begin
                m_valid = 1'b0;
            end
            tick();
            if (i >= 1 && i <= 4) begin
                check_output("mode_seq_valid", 32'(m_out_valid), 32'd1);
                check_output("mode_seq_data", 32'(m_out_data), 32'(mv[i-1].exp));
                check_output("mode_seq_mode", 32'(m_out_mode), 32'(mv[i-1].mode));
            end else begin
                check_output("mode_seq_idle", 32'(m_out_valid), 32'd0);
            end
        end

        // Backpressure: two items fill the pipe, the rest must wait
        ready_mode = 0;
        tick(); tick();
        m_data = bp[0].data; m_mode = bp[0].mode; m_valid = 1'b1;
        tick();
        m_data = bp[1].data; m_mode = bp[1].mode;
        tick();
        check_output("bp_in_ready_low", 32'(m_in_ready), 32'd0);
        check_output("bp_out_valid", 32'(m_out_valid), 32'd1);
        check_output("bp_out_data", 32'(m_out_data), 32'(bp[0].exp));
        m_data = bp[2].data; m_mode = bp[2].mode;
        for (int i = 0; i < 3; i++) begin
            tick();
            check_output("bp_hold_valid", 32'(m_out_valid), 32'd1);
            check_output("bp_hold_data", 32'(m_out_data), 32'(bp[0].exp));
            check_output("bp_hold_mode", 32'(m_out_mode), 32'(bp[0].mode));
            check_output("bp_hold_in_ready", 32'(m_in_ready), 32'd0);
        end
        ready_mode = 1;
        #3;
        check_output("bp_no_bubble", 32'(m_in_ready), 32'd1);
        tick();
        m_data = bp[3].data; m_mode = bp[3].mode;
        tick();
        m_valid = 1'b0;
        repeat (4) tick();
        check_output("bp_drained", 32'(sb_q.size()), 32'd0);

        // Random valid/ready traffic across all modes
        ready_mode = 2;
        base_push = pushed;
        base_recv = received;
        for (int n = 0; n < 1000; n++) begin
            if ($urandom_range(0, 3) == 0) begin
                m_valid = 1'b0;
                m_data  = 16'($urandom);
                tick();
            end
            apply_stimulus(16'($urandom), 2'($urandom_range(0, 3)));
        end
        wait_cnt = 0;
        while (sb_q.size() != 0 && wait_cnt < 300) begin
            tick();
            wait_cnt++;
        end
        check_output("rand_drained", 32'(sb_q.size()), 32'd0);
        check_output("rand_pushed", 32'(pushed - base_push), 32'd1000);
        check_output("rand_received", 32'(received - base_recv), 32'd1000);

        // Asynchronous reset with two items in flight
        ready_mode = 0;
        tick(); tick();
        apply_stimulus(16'hFFFF, 2'b00);
        apply_stimulus(16'h0001, 2'b10);
        check_output("inflight_valid", 32'(m_out_valid), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check_output("async_rst_out_valid", 32'(m_out_valid), 32'd0);
        check_output("async_rst_out_data", 32'(m_out_data), 32'd0);
        check_output("async_rst_out_mode", 32'(m_out_mode), 32'd0);
        tick(); tick();
        rst_n = 1'b1;
        ready_mode = 1;
        for (int i = 0; i < 6; i++) begin
            tick();
            check_output("after_rst_no_stale", 32'(m_out_valid), 32'd0);
            check_output("after_rst_in_ready", 32'(m_in_ready), 32'd1);
        end
        check_output("after_rst_sb_empty", 32'(sb_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
